pipeline_control_fsm: RTL and testbench
=======================================

PIPELINE_CONTROL_FSM -- requirements
Module: pipeline_control_fsm

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 4, register-file address width.
REQ-002 SHALL have parameter RET_WAIT_CYCLES, default 3, cycles fetch is held after a decoded return (value 0 treated as 1).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 id_valid  in  1  decode stage holds a valid instruction.
REQ-006 id_reg_file_ren  in  2  decoder read enables; bit0 = src A read, bit1 = src B read.
REQ-007 id_src_a, id_src_b  in  REG_ADDR_W each  decode-stage source register addresses.
REQ-008 id_return, id_halt, id_illegal  in  1 each  decoder flags: return in pipeline, halt, illegal opcode.
REQ-009 ex_load  in  1  EX-stage instruction is a load; ex_dest  in  REG_ADDR_W  its destination register.
REQ-010 ex_branch_taken  in  1  EX-stage control transfer resolved taken.
REQ-011 resume  in  1  exit request from HALT or EXC.
REQ-012 irq  in  1  interrupt request (used only when PIPELINE_CTRL_IRQ_EN is defined).
REQ-013 pc_stall, if_id_stall, if_id_flush, id_ex_bubble  out  1 each  pipeline control to PC, IF/ID register and ID/EX register.
REQ-014 halted, exception  out  1 each  status flags; irq_ack  out  1  one-cycle interrupt acceptance pulse.

Function
REQ-015 SHALL implement states RUN, RET_WAIT, HALT, EXC; outputs decoded combinationally from state and inputs in the same cycle; transitions on next clk edge.
REQ-016 Load-use hazard SHALL be: ex_load & id_valid & ((ren[0] & id_src_a==ex_dest) | (ren[1] & id_src_b==ex_dest)).
REQ-017 RUN, event priority highest first: ex_branch_taken, id_illegal, id_return, id_halt, load-use, irq; only the highest-priority active event acts; id_* events require id_valid.
REQ-018 RUN + ex_branch_taken: if_id_flush=1, id_ex_bubble=1, stay RUN; decode-stage events that cycle discarded.
REQ-019 RUN + illegal: pc_stall=1, if_id_stall=1, id_ex_bubble=1; next EXC.
REQ-020 RUN + return: pc_stall=1, if_id_flush=1, id_ex_bubble=0 (return proceeds); load counter with RET_WAIT_CYCLES; next RET_WAIT.
REQ-021 RUN + halt: pc_stall=1, if_id_stall=1, id_ex_bubble=1; next HALT.
REQ-022 RUN + load-use: pc_stall=1, if_id_stall=1, id_ex_bubble=1 for that cycle only; stay RUN.
REQ-023 RUN, no event: all control outputs 0.
REQ-024 RET_WAIT: pc_stall=1, if_id_flush=1, id_ex_bubble=1; counter decrements each cycle; when counter==1 next RUN, giving exactly RET_WAIT_CYCLES cycles in RET_WAIT; all inputs except rst_n ignored.
REQ-025 HALT: pc_stall=1, if_id_stall=1, id_ex_bubble=1, halted=1; resume=1 -> next RUN (outputs held that cycle).
REQ-026 EXC: pc_stall=1, if_id_stall=1, id_ex_bubble=1, exception=1; only resume -> next RUN; irq ignored.
REQ-027 Outputs not listed for a state/event SHALL be 0; counter width SHALL hold RET_WAIT_CYCLES without overflow.

Reset
REQ-028 rst_n low SHALL immediately force state RUN, counter 0, and every output 0 regardless of other inputs, including mid-RET_WAIT, HALT or EXC.
REQ-029 First rising clk after rst_n rises SHALL evaluate RUN normally.

Configuration
REQ-030 Macro PIPELINE_CTRL_IRQ_EN defined: RUN + irq (no higher event) -> irq_ack=1, if_id_flush=1 for one cycle, stay RUN; HALT + irq -> irq_ack=1, next RUN (resume also accepted).
REQ-031 Macro undefined: irq ignored, irq_ack tied 0, no interrupt logic synthesised.

Verification
REQ-032 ex_load=1, ex_dest=5, id_valid=1, ren=01, id_src_a=5 -> one cycle pc_stall=if_id_stall=id_ex_bubble=1, then 0 once ex_load drops; ren=00 same regs -> no stall.
REQ-033 id_return=1 with RET_WAIT_CYCLES=3 -> cycle0 pc_stall=if_id_flush=1, bubble=0; cycles1-3 pc_stall=if_id_flush=id_ex_bubble=1; cycle4 RUN, outputs 0.
REQ-034 ex_branch_taken=1 and id_illegal=1 same cycle -> flush+bubble, stay RUN, exception stays 0.
REQ-035 id_halt=1 -> halted=1 from next cycle held for 10 cycles; resume pulse -> halted=0 the cycle after.
REQ-036 id_illegal=1 -> exception=1; rst_n low during EXC -> exception=0 and all outputs 0 immediately, without clk.
REQ-037 With PIPELINE_CTRL_IRQ_EN, irq=1 in HALT -> one-cycle irq_ack=1, next RUN; without it, same stimulus -> irq_ack=0, stays HALT.

Source files
------------

// File: rtl/pipeline_control_fsm_if.sv
// Decode/execute hazard inputs and pipeline control outputs of pipeline_control_fsm.
// master drives the decoder/EX-stage signals; slave is the control FSM side.
interface pipeline_control_fsm_if #(
    parameter int REG_ADDR_W = 4
);
    logic                  id_valid;
    logic [1:0]            id_reg_file_ren;
    logic [REG_ADDR_W-1:0] id_src_a;
    logic [REG_ADDR_W-1:0] id_src_b;
    logic                  id_return;
    logic                  id_halt;
    logic                  id_illegal;
    logic                  ex_load;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_branch_taken;
    logic                  resume;
    logic                  irq;
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic                  halted;
    logic                  exception;
    logic                  irq_ack;

    modport master (
        output id_valid, id_reg_file_ren, id_src_a, id_src_b, id_return, id_halt,
               id_illegal, ex_load, ex_dest, ex_branch_taken, resume, irq,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, halted, exception,
               irq_ack
    );

    modport slave (
        input  id_valid, id_reg_file_ren, id_src_a, id_src_b, id_return, id_halt,
               id_illegal, ex_load, ex_dest, ex_branch_taken, resume, irq,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, halted, exception,
               irq_ack
    );
endinterface

// File: rtl/pipeline_control_fsm.sv
// Pipeline hazard/flow controller: load-use stalls, branch flush, return wait, halt, exception.
// Define PIPELINE_CTRL_IRQ_EN to build the interrupt acceptance path (RUN and HALT).
//
// state    | meaning
// RUN      | normal issue, per-cycle hazard/event handling
// RET_WAIT | fetch held while a decoded return resolves
// HALT     | pipeline frozen until resume (or irq when enabled)
// EXC      | illegal opcode seen, frozen until resume
module pipeline_control_fsm #(
    parameter int REG_ADDR_W      = 4,
    parameter int RET_WAIT_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipeline_control_fsm_if.slave   bus
);
    localparam int RW    = (RET_WAIT_CYCLES < 1) ? 1 : RET_WAIT_CYCLES;
    localparam int CNT_W = $clog2(RW + 1);

    typedef enum logic [1:0] {RUN, RET_WAIT, HALT, EXC} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_use;
    logic               pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
    logic               halted, exception, irq_ack;
    logic [REG_ADDR_W-1:0] src_a, src_b, dest;

    assign src_a = bus.id_src_a;
    assign src_b = bus.id_src_b;
    assign dest  = bus.ex_dest;

    assign load_use = bus.ex_load & bus.id_valid &
                      ((bus.id_reg_file_ren[0] & (src_a == dest)) |
                       (bus.id_reg_file_ren[1] & (src_b == dest)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        exception    = 1'b0;
        irq_ack      = 1'b0;
        case (state_q)
            RUN: begin
                cnt_d = '0;
                if (bus.ex_branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (bus.id_valid && bus.id_illegal) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_d      = EXC;
                end else if (bus.id_valid && bus.id_return) begin
                    // the return itself proceeds into EX, so no bubble here
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    cnt_d       = CNT_W'(RW);
                    state_d     = RET_WAIT;
                end else if (bus.id_valid && bus.id_halt) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_d      = HALT;
                end else if (load_use) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
`ifdef PIPELINE_CTRL_IRQ_EN
                end else if (bus.irq) begin
                    irq_ack     = 1'b1;
                    if_id_flush = 1'b1;
`endif
                end
            end
            RET_WAIT: begin
                pc_stall     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                cnt_d        = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = RUN;
            end
            HALT: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
                halted       = 1'b1;
                if (bus.resume) state_d = RUN;
`ifdef PIPELINE_CTRL_IRQ_EN
                if (bus.irq) begin
                    irq_ack = 1'b1;
                    state_d = RUN;
                end
`endif
            end
            EXC: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
                exception    = 1'b1;
                if (bus.resume) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // reset must silence outputs immediately, even while RUN sees live events
    assign bus.pc_stall     = rst_n & pc_stall;
    assign bus.if_id_stall  = rst_n & if_id_stall;
    assign bus.if_id_flush  = rst_n & if_id_flush;
    assign bus.id_ex_bubble = rst_n & id_ex_bubble;
    assign bus.halted       = rst_n & halted;
    assign bus.exception    = rst_n & exception;
    assign bus.irq_ack      = rst_n & irq_ack;
endmodule

// File: tb/tb_pipeline_control_fsm.sv
// Scoreboard bench for pipeline_control_fsm: directed scenarios then random traffic,
// expected outputs from a behavioural model, compared by a separate monitor.
module tb_pipeline_control_fsm;
    localparam int AW = 4;
    localparam int RW = 3;

    typedef struct packed {
        logic          v;
        logic [1:0]    ren;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          ret;
        logic          halt;
        logic          ill;
        logic          ld;
        logic [AW-1:0] dest;
        logic          br;
        logic          res;
        logic          irq;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [6:0] exp_q[$];

    // behavioural model: 0 run, 1 return wait, 2 halted, 3 exception
    int mode = 0;
    int wait_left = 0;

    pipeline_control_fsm_if #(.REG_ADDR_W(AW)) bus ();

    pipeline_control_fsm #(.REG_ADDR_W(AW), .RET_WAIT_CYCLES(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    function automatic logic irq_enabled();
`ifdef PIPELINE_CTRL_IRQ_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // returns {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, halted, exception, irq_ack}
    function automatic logic [6:0] model_step(stim_t s, logic rst);
        logic stall_all, hz;
        logic [6:0] o;
        o = '0;
        if (!rst) begin
            mode = 0;
            wait_left = 0;
            return o;
        end
        hz = s.ld && s.v && ((s.ren[0] && s.a == s.dest) || (s.ren[1] && s.b == s.dest));
        stall_all = 1'b0;
        if (mode == 1) begin
            o = 7'b1011000;
            wait_left--;
            if (wait_left == 0) mode = 0;
        end else if (mode == 2) begin
            o = 7'b1101100;
            if (irq_enabled() && s.irq) o[0] = 1'b1;
            if (s.res || (irq_enabled() && s.irq)) mode = 0;
        end else if (mode == 3) begin
            o = 7'b1101010;
            if (s.res) mode = 0;
        end else begin
            if (s.br) o = 7'b0011000;
            else if (s.v && s.ill) begin stall_all = 1'b1; mode = 3; end
            else if (s.v && s.ret) begin o = 7'b1010000; mode = 1; wait_left = RW; end
            else if (s.v && s.halt) begin stall_all = 1'b1; mode = 2; end
            else if (hz) stall_all = 1'b1;
            else if (irq_enabled() && s.irq) o = 7'b0010001;
            if (stall_all) o = 7'b1101000;
        end
        return o;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.v    = ($urandom_range(0, 3) != 0);
        s.ren  = 2'($urandom_range(0, 3));
        s.a    = AW'($urandom_range(0, 3));
        s.b    = AW'($urandom_range(0, 3));
        s.ret  = ($urandom_range(0, 19) == 0);
        s.halt = ($urandom_range(0, 19) == 0);
        s.ill  = ($urandom_range(0, 24) == 0);
        s.ld   = ($urandom_range(0, 2) == 0);
        s.dest = AW'($urandom_range(0, 3));
        s.br   = ($urandom_range(0, 7) == 0);
        s.res  = ($urandom_range(0, 3) == 0);
        s.irq  = ($urandom_range(0, 5) == 0);
        return s;
    endfunction

    task automatic step(input stim_t s, input logic rst);
        @(negedge clk);
        bus.id_valid        = s.v;
        bus.id_reg_file_ren = s.ren;
        bus.id_src_a        = s.a;
        bus.id_src_b        = s.b;
        bus.id_return       = s.ret;
        bus.id_halt         = s.halt;
        bus.id_illegal      = s.ill;
        bus.ex_load         = s.ld;
        bus.ex_dest         = s.dest;
        bus.ex_branch_taken = s.br;
        bus.resume          = s.res;
        bus.irq             = s.irq;
        rst_n               = rst;
        #1;
        exp_q.push_back(model_step(s, rst));
    endtask

    // asserts reset mid-cycle (no clock edge) and checks outputs drop at once
    task automatic async_reset_check();
        logic [6:0] act;
        #4;
        rst_n = 1'b0;
        #1;
        act = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_bubble,
               bus.halted, bus.exception, bus.irq_ack};
        checks++;
        if (act !== 7'b0) begin
            errors++;
            $display("FAIL async_reset t=%0t outputs got=%b want=0000000", $time, act);
        end
        mode = 0;
        wait_left = 0;
    endtask

    initial begin : monitor
        logic [6:0] act, exp;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_bubble,
                       bus.halted, bus.exception, bus.irq_ack};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL outputs cycle=%0d {pc_stall,if_id_stall,if_id_flush,bubble,halted,exception,irq_ack} got=%b want=%b",
                             cyc, act, exp);
                end
            end
        end
    end

    initial begin : driver
        stim_t s;
        step(idle(), 1'b0);
        s = idle(); s.br = 1'b1; s.v = 1'b1; s.ill = 1'b1;
        step(s, 1'b0);
        step(idle(), 1'b1);

        // load-use on src A, then load drops, then no read enables
        s = idle(); s.ld = 1'b1; s.dest = 4'd5; s.v = 1'b1; s.ren = 2'b01; s.a = 4'd5;
        step(s, 1'b1);
        s.ld = 1'b0;
        step(s, 1'b1);
        s.ld = 1'b1; s.ren = 2'b00; s.b = 4'd5;
        step(s, 1'b1);
        s.ren = 2'b10;
        step(s, 1'b1);

        // return and its wait window
        s = idle(); s.v = 1'b1; s.ret = 1'b1;
        step(s, 1'b1);
        s = idle(); s.v = 1'b1; s.ill = 1'b1; s.halt = 1'b1;
        for (int i = 0; i < RW; i++) step(s, 1'b1);
        step(idle(), 1'b1);

        // branch beats illegal
        s = idle(); s.br = 1'b1; s.v = 1'b1; s.ill = 1'b1;
        step(s, 1'b1);
        step(idle(), 1'b1);

        // halt held, then resume
        s = idle(); s.v = 1'b1; s.halt = 1'b1;
        step(s, 1'b1);
        for (int i = 0; i < 10; i++) step(idle(), 1'b1);
        s = idle(); s.res = 1'b1;
        step(s, 1'b1);
        step(idle(), 1'b1);

        // irq while halted
        s = idle(); s.v = 1'b1; s.halt = 1'b1;
        step(s, 1'b1);
        step(idle(), 1'b1);
        s = idle(); s.irq = 1'b1;
        step(s, 1'b1);
        step(idle(), 1'b1);
        s = idle(); s.res = 1'b1;
        step(s, 1'b1);

        // exception, irq ignored, async reset inside EXC
        s = idle(); s.v = 1'b1; s.ill = 1'b1;
        step(s, 1'b1);
        s = idle(); s.irq = 1'b1;
        step(s, 1'b1);
        step(idle(), 1'b1);
        async_reset_check();
        s = idle(); s.br = 1'b1; s.v = 1'b1; s.halt = 1'b1;
        step(s, 1'b0);
        step(idle(), 1'b1);

        for (int n = 0; n < 3000; n++) begin
            step(rand_stim(), 1'b1);
            if ($urandom_range(0, 149) == 0) begin
                async_reset_check();
                step(rand_stim(), 1'b0);
            end
        end

        repeat (2) @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
